// File: rtl/uart_bus_master_if.sv
// Data-memory bus port of the UART bus master: arbitration handshake plus
// single-word read/write strobes, address and data.
interface uart_bus_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;

    modport master (
        output bus_req, MemRd, MemWr, Addr, WrData,
        input  bus_gnt, RdData
    );

    modport slave (
        input  bus_req, MemRd, MemWr, Addr, WrData,
        output bus_gnt, RdData
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: receives 'W'/'R' commands with a big-endian
// address (and write data), performs one word access on the data-memory bus
// after winning arbitration, and replies 'K', the read word, 'E' or '?'.
module uart_bus_master #(
    parameter int CLKS_PER_BIT  = 7292,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic RxSerial,
    output logic TxSerial,
    output logic busy,
    uart_bus_master_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(FRAME_TIMEOUT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_RESP} state_t;

    // receiver state
    logic [1:0]    rxSync;
    logic          rxPrev;
    rxState_t      rxState;
    logic [CW-1:0] rxCnt;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift;
    logic          rxValid;
    logic          rxErr;

    // transmitter state
    logic          txActive;
    logic [CW-1:0] txCnt;
    logic [3:0]    txBit;
    logic [9:0]    txShift;
    logic          txTake;

    // command state
    state_t        state;
    logic          isWrite;
    logic [1:0]    byteCnt;
    logic [TW-1:0] toCnt;
    logic [31:0]   respBuf;
    logic [2:0]    respLeft;

    wire rxS = rxSync[1];

    // Synchronise the line, qualify the start bit at half-bit, sample data and stop at bit centres.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxSync  <= 2'b11;
            rxPrev  <= 1'b1;
            rxState <= RX_IDLE;
            rxCnt   <= '0;
            rxBit   <= '0;
            rxShift <= '0;
            rxValid <= 1'b0;
            rxErr   <= 1'b0;
        end else begin
            rxSync  <= {rxSync[0], RxSerial};
            rxPrev  <= rxS;
            rxValid <= 1'b0;
            rxErr   <= 1'b0;
            case (rxState)
                RX_IDLE: begin
                    rxCnt <= '0;
                    if (rxPrev && !rxS) rxState <= RX_START;
                end
                RX_START: begin
                    if (rxCnt == HALF_LAST) begin
                        rxCnt   <= '0;
                        rxBit   <= '0;
                        rxState <= rxS ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxShift <= {rxS, rxShift[7:1]};
                        rxBit   <= rxBit + 1'b1;
                        if (rxBit == 3'd7) rxState <= RX_STOP;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxValid <= rxS;
                        rxErr   <= !rxS;
                        rxState <= RX_IDLE;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

    // A new frame is loaded either from idle or on the last clock of the
    // previous stop bit, so queued reply bytes go out with no gap.
    wire txLast = txActive && (txBit == 4'd9) && (txCnt == BIT_LAST);
    assign txTake   = (state == S_RESP) && (respLeft != 3'd0) && (!txActive || txLast);
    assign TxSerial = txActive ? txShift[0] : 1'b1;
    assign busy     = (state != S_IDLE);

    // Shift out start, 8 data bits LSB first and stop, one bit per CLKS_PER_BIT clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txActive <= 1'b0;
            txCnt    <= '0;
            txBit    <= '0;
            txShift  <= 10'h3FF;
        end else if (txTake) begin
            txActive <= 1'b1;
            txCnt    <= '0;
            txBit    <= '0;
            txShift  <= {1'b1, respBuf[31:24], 1'b0};
        end else if (txActive) begin
            if (txCnt == BIT_LAST) begin
                txCnt <= '0;
                if (txBit == 4'd9) begin
                    txActive <= 1'b0;
                end else begin
                    txBit   <= txBit + 1'b1;
                    txShift <= {1'b1, txShift[9:1]};
                end
            end else begin
                txCnt <= txCnt + 1'b1;
            end
        end
    end

    // Command decoder, bus access sequencing and reply queueing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            isWrite     <= 1'b0;
            byteCnt     <= '0;
            toCnt       <= '0;
            respBuf     <= '0;
            respLeft    <= '0;
            bus.bus_req <= 1'b0;
            bus.MemRd   <= 1'b0;
            bus.MemWr   <= 1'b0;
            bus.Addr    <= '0;
            bus.WrData  <= '0;
        end else begin
            bus.MemRd <= 1'b0;
            bus.MemWr <= 1'b0;
            case (state)
                S_IDLE: begin
                    byteCnt <= '0;
                    toCnt   <= '0;
                    if (rxErr) begin
                        respBuf  <= {8'h45, 24'h0};
                        respLeft <= 3'd1;
                        state    <= S_RESP;
                    end else if (rxValid) begin
                        if (rxShift == 8'h57 || rxShift == 8'h52) begin
                            isWrite <= (rxShift == 8'h57);
                            state   <= S_ADDR;
                        end else begin
                            respBuf  <= {8'h3F, 24'h0};
                            respLeft <= 3'd1;
                            state    <= S_RESP;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rxErr) begin
                        respBuf  <= {8'h45, 24'h0};
                        respLeft <= 3'd1;
                        state    <= S_RESP;
                    end else if (rxValid) begin
                        toCnt   <= '0;
                        byteCnt <= byteCnt + 1'b1;
                        if (state == S_ADDR) bus.Addr   <= {bus.Addr[23:0], rxShift};
                        else                 bus.WrData <= {bus.WrData[23:0], rxShift};
                        if (byteCnt == 2'd3) begin
                            if (state == S_ADDR && rxShift[1:0] != 2'b00) begin
                                respBuf  <= {8'h45, 24'h0};
                                respLeft <= 3'd1;
                                state    <= S_RESP;
                            end else if (state == S_ADDR && isWrite) begin
                                state <= S_DATA;
                            end else begin
                                bus.bus_req <= 1'b1;
                                state       <= S_REQ;
                            end
                        end
                    end else if (toCnt == TO_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.bus_gnt) begin
                        bus.MemWr <= isWrite;
                        bus.MemRd <= !isWrite;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    bus.bus_req <= 1'b0;
                    respBuf     <= isWrite ? {8'h4B, 24'h0} : bus.RdData;
                    respLeft    <= isWrite ? 3'd1 : 3'd4;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (txTake) begin
                        respBuf  <= {respBuf[23:0], 8'h00};
                        respLeft <= respLeft - 1'b1;
                    end else if (respLeft == 3'd0 && !txActive) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: a host UART drives commands, a serial
// monitor decodes replies, and a small memory/arbiter model answers the bus.
module tb_uart_bus_master;
    localparam int CPB = 16;
    localparam int FTO = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic RxSerial = 1'b1;
    logic TxSerial;
    logic busy;
    logic gntAllow = 1'b1;

    uart_bus_master_if bif ();

    uart_bus_master #(.CLKS_PER_BIT(CPB), .FRAME_TIMEOUT(FTO)) dut (
        .clk(clk), .rst(rst), .RxSerial(RxSerial), .TxSerial(TxSerial),
        .busy(busy), .bus(bif.master)
    );

    always #5 clk = ~clk;

    // memory / arbiter model
    logic [31:0] memArr [16];
    logic [31:0] lastWrAddr = '0, lastWrData = '0, lastRdAddr = '0;
    int wrCount = 0, rdCount = 0, strobeViol = 0;
    logic gntLast = 1'b0;
    logic [7:0] rxQ [$];
    int nChecks = 0, nFail = 0;

    assign bif.bus_gnt = bif.bus_req & gntAllow;
    assign bif.RdData  = memArr[bif.Addr[5:2]];

    always @(posedge clk) gntLast <= bif.bus_gnt;

    always @(negedge clk) begin
        if (bif.MemWr) begin
            wrCount++;
            lastWrAddr = bif.Addr;
            lastWrData = bif.WrData;
            memArr[bif.Addr[5:2]] = bif.WrData;
            $display("bus write addr=%h data=%h", bif.Addr, bif.WrData);
        end
        if (bif.MemRd) begin
            rdCount++;
            lastRdAddr = bif.Addr;
            $display("bus read  addr=%h data=%h", bif.Addr, bif.RdData);
        end
        if ((bif.MemWr || bif.MemRd) && !(bif.bus_req && gntLast)) strobeViol++;
    end

    // host-side receiver for the DUT's TX line
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (TxSerial == 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = TxSerial;
                end
                repeat (CPB) @(negedge clk);
                rxQ.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        RxSerial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxSerial = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxSerial = stopBit;
        repeat (CPB) @(negedge clk);
        RxSerial = 1'b1;
        repeat (2) @(negedge clk);
        $display("host sent byte %h stop=%b", b, stopBit);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) sendByte(w[8*i +: 8], 1'b1);
    endtask

    task automatic expectBytes(input string tag, input logic [31:0] val, input int n);
        logic [31:0] got;
        for (int c = 0; c < (n + 2) * 12 * CPB && rxQ.size() < n; c++) @(negedge clk);
        check({tag, "_len"}, rxQ.size(), n);
        for (int i = 0; i < n && rxQ.size() > 0; i++) begin
            got = {24'h0, rxQ.pop_front()};
            check({tag, "_byte"}, got, (val >> (8 * (n - 1 - i))) & 32'hFF);
            $display("reply %s byte %0d = %h", tag, i, got[7:0]);
        end
    endtask

    task automatic waitIdle(input string tag);
        for (int c = 0; c < 40 * CPB && busy; c++) @(negedge clk);
        check({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic waitReq(input string tag);
        for (int c = 0; c < 40 * CPB && !bif.bus_req; c++) @(negedge clk);
        check({tag, "_req"}, {31'h0, bif.bus_req}, 32'h1);
    endtask

    initial begin
        int rdBefore, wrBefore;
        for (int i = 0; i < 16; i++) memArr[i] = 32'h1000_0000 + i;
        memArr[0] = 32'hCAFEF00D;
        memArr[4] = 32'h0BADF00D;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx",    {31'h0, TxSerial},    32'h1);
        check("rst_req",   {31'h0, bif.bus_req}, 32'h0);
        check("rst_rd",    {31'h0, bif.MemRd},   32'h0);
        check("rst_wr",    {31'h0, bif.MemWr},   32'h0);
        check("rst_addr",  bif.Addr,             32'h0);
        check("rst_wdata", bif.WrData,           32'h0);
        check("rst_busy",  {31'h0, busy},        32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // write then read back
        sendByte(8'h57, 1'b1); sendWord(32'h8); sendWord(32'hDEADBEEF);
        expectBytes("w_ack", 32'h4B, 1);
        check("w_count", wrCount, 1);
        check("w_addr", lastWrAddr, 32'h8);
        check("w_data", lastWrData, 32'hDEADBEEF);
        waitIdle("w");
        sendByte(8'h52, 1'b1); sendWord(32'h8);
        expectBytes("r_data", 32'hDEADBEEF, 4);
        check("r_count", rdCount, 1);
        waitIdle("r");

        // grant stall
        gntAllow = 1'b0;
        sendByte(8'h52, 1'b1); sendWord(32'h10);
        waitReq("stall");
        rdBefore = rdCount;
        repeat (500) @(negedge clk);
        check("stall_nostrobe", rdCount, rdBefore);
        check("stall_req_held", {31'h0, bif.bus_req}, 32'h1);
        #1 gntAllow = 1'b1;
        @(negedge clk);
        check("stall_strobe", {31'h0, bif.MemRd}, 32'h1);
        check("stall_addr", bif.Addr, 32'h10);
        @(negedge clk);
        check("stall_strobe_end", {31'h0, bif.MemRd}, 32'h0);
        check("stall_req_drop", {31'h0, bif.bus_req}, 32'h0);
        check("stall_one", rdCount, rdBefore + 1);
        expectBytes("stall_data", 32'h0BADF00D, 4);
        waitIdle("stall");

        // misaligned and unknown commands
        rdBefore = rdCount;
        sendByte(8'h52, 1'b1); sendWord(32'h6);
        expectBytes("misalign", 32'h45, 1);
        check("misalign_nord", rdCount, rdBefore);
        waitIdle("misalign");
        sendByte(8'h41, 1'b1);
        expectBytes("unknown", 32'h3F, 1);
        waitIdle("unknown");

        // framing error inside the address bytes
        sendByte(8'h52, 1'b1); sendByte(8'h00, 1'b1); sendByte(8'h00, 1'b0);
        expectBytes("frame_err", 32'h45, 1);
        waitIdle("frame_err");
        check("frame_nord", rdCount, rdBefore);

        // quarter-bit glitch
        RxSerial = 1'b0;
        repeat (CPB/4) @(negedge clk);
        RxSerial = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        check("glitch_noreply", rxQ.size(), 0);

        // inter-byte timeout
        sendByte(8'h57, 1'b1); sendByte(8'h00, 1'b1); sendByte(8'h00, 1'b1);
        check("to_busy_before", {31'h0, busy}, 32'h1);
        repeat (FTO + 10) @(negedge clk);
        check("to_idle", {31'h0, busy}, 32'h0);
        check("to_silent", rxQ.size(), 0);
        sendByte(8'h52, 1'b1); sendWord(32'h0);
        expectBytes("to_after", 32'hCAFEF00D, 4);
        waitIdle("to_after");

        // reset while requesting the bus
        gntAllow = 1'b0;
        sendByte(8'h52, 1'b1); sendWord(32'h0);
        waitReq("rstreq");
        #1 rst = 1'b0;
        #1;
        check("rstreq_req", {31'h0, bif.bus_req}, 32'h0);
        check("rstreq_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        gntAllow = 1'b1;
        rdBefore = rdCount;
        wrBefore = wrCount;
        repeat (50) @(negedge clk);
        check("rstreq_nord", rdCount, rdBefore);
        check("rstreq_nowr", wrCount, wrBefore);

        // reset while transmitting the reply
        sendByte(8'h52, 1'b1); sendWord(32'h0);
        for (int c = 0; c < 40 * CPB && TxSerial; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("rstresp_txlow", {31'h0, TxSerial}, 32'h0);
        #1 rst = 1'b0;
        #1;
        check("rstresp_tx", {31'h0, TxSerial}, 32'h1);
        check("rstresp_req", {31'h0, bif.bus_req}, 32'h0);
        check("rstresp_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        check("strobe_qualified", strobeViol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
